// File: rtl/tag_ct_coalescer.sv
// ---------------------------------------------------------------------------
// tag_ct_coalescer
//
// Purpose:
//   Sits on the tag/count channel downstream of the BD tag-split stage and
//   merges consecutive words carrying the same tag into one word whose count
//   is the sum of the merged counts. Word order is preserved. A held word
//   leaves the block when a different tag arrives, when adding the next
//   count would exceed the count field, when the channel has been idle for
//   'timeout_i' cycles, or when coalescing is disabled.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   in_tag_i       input tag            (NTAG bits)
//   in_ct_i        input count          (NCT bits)
//   in_v_i         input valid
//   in_a_o         input ack (combinational); transfer on in_v_i && in_a_o
//   out_tag_o      output tag           (registered)
//   out_ct_o       output count         (registered)
//   out_v_o        output valid         (registered)
//   out_a_i        output ack; transfer on out_v_o && out_a_i
//   coalesce_en_i  1 = merge equal tags, 0 = pass every word through
//   timeout_i      idle cycles before a held word flushes (0 = next cycle)
// ---------------------------------------------------------------------------
module tag_ct_coalescer #(
    parameter int unsigned NTAG     = 11,
    parameter int unsigned NCT      = 9,
    parameter int unsigned NTIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NTAG-1:0]     in_tag_i,
    input  logic [NCT-1:0]      in_ct_i,
    input  logic                in_v_i,
    output logic                in_a_o,
    output logic [NTAG-1:0]     out_tag_o,
    output logic [NCT-1:0]      out_ct_o,
    output logic                out_v_o,
    input  logic                out_a_i,
    input  logic                coalesce_en_i,
    input  logic [NTIMEOUT-1:0] timeout_i
);

    // Largest count a single word can carry, widened by one bit so it can be
    // compared against the unclipped sum.
    localparam logic [NCT:0]          CT_MAX   = {1'b0, {NCT{1'b1}}};
    localparam logic [NTIMEOUT-1:0]   IDLE_MAX = {NTIMEOUT{1'b1}};
    localparam logic [NTIMEOUT-1:0]   IDLE_ONE = {{(NTIMEOUT-1){1'b0}}, 1'b1};

    // Hold register: the word currently being accumulated.
    logic [NTAG-1:0]     h_tag_q,   h_tag_d;
    logic [NCT-1:0]      h_ct_q,    h_ct_d;
    logic                h_full_q,  h_full_d;

    // Output register.
    logic [NTAG-1:0]     out_tag_q, out_tag_d;
    logic [NCT-1:0]      out_ct_q,  out_ct_d;
    logic                out_v_q,   out_v_d;

    // Cycles since the hold register last changed.
    logic [NTIMEOUT-1:0] idle_cnt_q, idle_cnt_d;

    // Decode signals.
    logic [NCT:0]        sum_s;
    logic                o_free_s;
    logic                match_s;
    logic                in_a_s;
    logic                xfer_s;
    logic                load_s;
    logic                merge_s;
    logic                evict_s;
    logic                flush_s;

    // Merge/accept decode. The sum keeps its carry bit so an overflowing
    // same-tag pair is seen as a mismatch instead of wrapping.
    always_comb begin
        sum_s    = {1'b0, h_ct_q} + {1'b0, in_ct_i};
        o_free_s = (!out_v_q) || out_a_i;
        match_s  = h_full_q && coalesce_en_i &&
                   (in_tag_i == h_tag_q) && (sum_s <= CT_MAX);

        // An empty hold always takes the word, a mergeable word always fits,
        // otherwise the held word must be able to move into the output.
        if (reset_i) begin
            in_a_s = 1'b0;
        end else if (!h_full_q) begin
            in_a_s = 1'b1;
        end else if (match_s) begin
            in_a_s = 1'b1;
        end else begin
            in_a_s = o_free_s;
        end

        xfer_s  = in_v_i && in_a_s;
        load_s  = xfer_s && !h_full_q;
        merge_s = xfer_s &&  h_full_q &&  match_s;
        evict_s = xfer_s &&  h_full_q && !match_s;

        // Flushing is only considered on cycles with no input transfer; with
        // coalescing off the word leaves on the very next free cycle.
        flush_s = (!xfer_s) && h_full_q && o_free_s &&
                  ((idle_cnt_q >= timeout_i) || (!coalesce_en_i));
    end

    // Next-state logic for the hold register and the idle counter.
    always_comb begin
        h_tag_d    = h_tag_q;
        h_ct_d     = h_ct_q;
        h_full_d   = h_full_q;
        idle_cnt_d = idle_cnt_q;

        if (load_s || evict_s) begin
            h_tag_d    = in_tag_i;
            h_ct_d     = in_ct_i;
            h_full_d   = 1'b1;
            idle_cnt_d = '0;
        end else if (merge_s) begin
            h_ct_d     = sum_s[NCT-1:0];
            idle_cnt_d = '0;
        end else if (flush_s) begin
            h_full_d   = 1'b0;
            idle_cnt_d = '0;
        end else if (h_full_q && (idle_cnt_q != IDLE_MAX)) begin
            idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Next-state logic for the output register. A reload in the same cycle
    // as a consumption keeps out_v high, so there is no bubble.
    always_comb begin
        out_tag_d = out_tag_q;
        out_ct_d  = out_ct_q;
        out_v_d   = out_v_q;

        if (evict_s || flush_s) begin
            out_tag_d = h_tag_q;
            out_ct_d  = h_ct_q;
            out_v_d   = 1'b1;
        end else if (out_v_q && out_a_i) begin
            out_v_d   = 1'b0;
        end else begin
            out_v_d   = out_v_q;
        end
    end

    // State registers; reset discards any held or pending word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_tag_q    <= '0;
            h_ct_q     <= '0;
            h_full_q   <= 1'b0;
            out_tag_q  <= '0;
            out_ct_q   <= '0;
            out_v_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            h_tag_q    <= h_tag_d;
            h_ct_q     <= h_ct_d;
            h_full_q   <= h_full_d;
            out_tag_q  <= out_tag_d;
            out_ct_q   <= out_ct_d;
            out_v_q    <= out_v_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign in_a_o    = in_a_s;
    assign out_tag_o = out_tag_q;
    assign out_ct_o  = out_ct_q;
    assign out_v_o   = out_v_q;

endmodule
